leiwand_rv32_wb_interconnect: RTL and testbench
===============================================

Name: leiwand_rv32_wb_interconnect

Overview:
- Single-master, two-slave Wishbone (pipelined) interconnect that sits directly downstream of leiwand_rv32_core and upstream of the internal SRAM and ROM instances.
- Decodes the master address into slave strobes and routes the selected slave's ack/data/stall back to the core.
- Allows one outstanding transaction at a time.
- Terminates unmapped accesses and hung slaves with a bus error, so the core never deadlocks.

Parameters:
MEM_WIDTH, 32, address/data width
SRAM_BASE, 32'h10000000, byte base address of SRAM window
SRAM_WORDS, 128, SRAM window size in 32-bit words
ROM_BASE, 32'h20000000, byte base address of ROM window
ROM_WORDS, 128, ROM window size in 32-bit words
TIMEOUT_CYCLES, 16, max cycles in WAIT before bus error (>=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
m_cyc  in  1  master cycle
m_stb  in  1  master strobe
m_we  in  1  master write enable
m_addr  in  MEM_WIDTH  master byte address
m_data_w  in  MEM_WIDTH  master write data (fanned out unchanged to slaves)
m_data_r  out  MEM_WIDTH  read data to master
m_ack  out  1  ack to master
m_err  out  1  bus error to master
m_stall  out  1  stall to master
s0_stb  out  1  SRAM strobe
s0_ack  in  1  SRAM ack
s0_data_r  in  MEM_WIDTH  SRAM read data
s0_stall  in  1  SRAM stall
s1_stb  out  1  ROM strobe
s1_ack  in  1  ROM ack
s1_data_r  in  MEM_WIDTH  ROM read data
s1_stall  in  1  ROM stall

Behaviour:
- Decode (combinational):
  - hit0 = m_addr in [SRAM_BASE, SRAM_BASE+4*SRAM_WORDS).
  - hit1 = m_addr in [ROM_BASE, ROM_BASE+4*ROM_WORDS).
  - Upper bounds are exclusive. Compare at MEM_WIDTH+1 bits so base+size never wraps.
- req = m_cyc & m_stb.
- State machine: IDLE, WAIT, ERR. Registered state; sel register (NONE/S0/S1); timeout counter of width $clog2(TIMEOUT_CYCLES)+1.
- Reset (async, reset==0): state=IDLE, sel=NONE, counter=0, m_err=0. Combinational outputs therefore settle to m_ack=0, m_stall=0, s0_stb=0, s1_stb=0, m_data_r=0.
- IDLE:
  - sK_stb = req & hitK.
  - m_stall = (hit0 & s0_stall) | (hit1 & s1_stall); 0 when unmapped.
  - req & hitK & !sK_stall -> latch sel=K, counter=0, go WAIT.
  - req & no hit -> go ERR.
  - req & hitK & sK_stall -> stay IDLE, request held by master.
- WAIT:
  - m_stall=1; s0_stb=s1_stb=0.
  - m_ack = ack of selected slave; m_data_r = selected slave data, combinational, zero added latency.
  - On m_ack: go IDLE, sel=NONE.
  - Otherwise counter++. If counter reaches TIMEOUT_CYCLES-1 without ack: m_err=1 registered, go ERR.
  - Ack and timeout in the same cycle: ack wins, no err.
  - m_cyc deasserted in WAIT: abort to IDLE next cycle; no ack/err forwarded.
- ERR:
  - m_stall=1; m_err=1 for exactly one cycle (registered), then IDLE.
  - Unmapped request error latency: m_err high the cycle after the accepted request.
- Stray ack/data from a non-selected slave is ignored. m_data_r=0 whenever m_ack=0.
- m_ack and m_err are never high in the same cycle.

Optional Feature:
LEIWAND_RV32_WB_ROM_WP_EN
- Defined: a write (m_we=1) hitting the ROM window is not forwarded (s1_stb stays 0). It is treated as unmapped: ERR, m_err pulse one cycle later. ROM reads are unaffected.
- Undefined: ROM writes are forwarded like any other access.

Test Plan:
- Read 0x10000008, SRAM acks 1 cycle after stb with 0xDEADBEEF -> s0_stb high 1 cycle, m_ack high 1 cycle, m_data_r=0xDEADBEEF, s1_stb never high.
- Write 0x2000001C, 0x12345678, ROM s1_stall high 2 cycles then accepts -> m_stall high 2 cycles, s1_stb held 3 cycles, single m_ack. With LEIWAND_RV32_WB_ROM_WP_EN: s1_stb=0, m_err pulse next cycle.
- Read 0x30000000 (unmapped) -> no slave stb, m_err=1 exactly one cycle after request, m_ack=0, then IDLE.
- Read 0x10000000 with SRAM never acking, TIMEOUT_CYCLES=16 -> m_err pulses 16 cycles after acceptance, state returns to IDLE; next request accepted normally.
- Boundary: 0x100001FC hits SRAM, 0x10000200 errors; ack on the timeout cycle -> m_ack, no m_err.
- Reset asserted low mid-WAIT -> all outputs 0 immediately (async); after release, first request decodes normally.

Source files
------------

// File: rtl/leiwand_rv32_wb_interconnect_if.sv
// Wishbone (pipelined) bundle between leiwand_rv32_core, the interconnect and
// the SRAM/ROM slaves. The master write data and address are shared by both slaves.
interface leiwand_rv32_wb_interconnect_if #(
  parameter int unsigned MEM_WIDTH = 32
);

  logic                 m_cyc;
  logic                 m_stb;
  logic                 m_we;
  logic [MEM_WIDTH-1:0] m_addr;
  logic [MEM_WIDTH-1:0] m_data_w;
  logic [MEM_WIDTH-1:0] m_data_r;
  logic                 m_ack;
  logic                 m_err;
  logic                 m_stall;

  logic                 s0_stb;
  logic                 s0_ack;
  logic [MEM_WIDTH-1:0] s0_data_r;
  logic                 s0_stall;

  logic                 s1_stb;
  logic                 s1_ack;
  logic [MEM_WIDTH-1:0] s1_data_r;
  logic                 s1_stall;

  // Core side: issues requests, receives responses.
  modport master (
    output m_cyc, m_stb, m_we, m_addr, m_data_w,
    input  m_data_r, m_ack, m_err, m_stall
  );

  // Interconnect side: receives the core request, drives slave strobes.
  modport slave (
    input  m_cyc, m_stb, m_we, m_addr, m_data_w,
    output m_data_r, m_ack, m_err, m_stall,
    output s0_stb, s1_stb,
    input  s0_ack, s0_data_r, s0_stall,
    input  s1_ack, s1_data_r, s1_stall
  );

  // SRAM and ROM views.
  modport sram (
    input  s0_stb, m_we, m_addr, m_data_w,
    output s0_ack, s0_data_r, s0_stall
  );

  modport rom (
    input  s1_stb, m_we, m_addr, m_data_w,
    output s1_ack, s1_data_r, s1_stall
  );

endinterface

// File: rtl/leiwand_rv32_wb_interconnect.sv
// Single-master, two-slave pipelined Wishbone interconnect (SRAM = slave 0, ROM = slave 1).
// One outstanding transaction; unmapped accesses and hung slaves end in a one-cycle bus error.
// Optional macro LEIWAND_RV32_WB_ROM_WP_EN: writes into the ROM window are not forwarded and
// are terminated with a bus error as if unmapped.
module leiwand_rv32_wb_interconnect #(
  parameter int unsigned          MEM_WIDTH      = 32,
  parameter logic [MEM_WIDTH-1:0] SRAM_BASE      = 32'h1000_0000,
  parameter int unsigned          SRAM_WORDS     = 128,
  parameter logic [MEM_WIDTH-1:0] ROM_BASE       = 32'h2000_0000,
  parameter int unsigned          ROM_WORDS      = 128,
  parameter int unsigned          TIMEOUT_CYCLES = 16
) (
  input logic                          clk,
  input logic                          reset,
  leiwand_rv32_wb_interconnect_if.slave bus
);

  // One extra bit so base + size cannot wrap around the address space.
  localparam int unsigned        CW      = MEM_WIDTH + 1;
  localparam logic [CW-1:0]      SRAM_LO = {1'b0, SRAM_BASE};
  localparam logic [CW-1:0]      SRAM_HI = SRAM_LO + (CW'(SRAM_WORDS) << 2);
  localparam logic [CW-1:0]      ROM_LO  = {1'b0, ROM_BASE};
  localparam logic [CW-1:0]      ROM_HI  = ROM_LO + (CW'(ROM_WORDS) << 2);

  localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  // Last WAIT count that may still see an ack; one more miss means timeout.
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 2);

  typedef enum logic [1:0] {StIdle, StWait, StErr} state_t;
  typedef enum logic [1:0] {SelNone, SelS0, SelS1} sel_t;

  state_t               state_q, state_d;
  sel_t                 sel_q, sel_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 err_q, err_d;

  logic [CW-1:0]        addr_ext;
  logic                 req;
  logic                 hit0;
  logic                 hit1_win;
  logic                 hit1;

  logic                 sel_ack;
  logic [MEM_WIDTH-1:0] sel_data;

  logic                 stb0;
  logic                 stb1;
  logic                 stall;
  logic                 ack;
  logic [MEM_WIDTH-1:0] data_r;

  // Write data is consumed by the slaves directly from the shared bundle.
  logic                 unused_inputs;
  assign unused_inputs = ^{bus.m_data_w, bus.m_we};

  assign req      = bus.m_cyc & bus.m_stb;
  assign addr_ext = {1'b0, bus.m_addr};
  assign hit0     = (addr_ext >= SRAM_LO) && (addr_ext < SRAM_HI);
  assign hit1_win = (addr_ext >= ROM_LO) && (addr_ext < ROM_HI) && !hit0;

`ifdef LEIWAND_RV32_WB_ROM_WP_EN
  assign hit1 = hit1_win & ~bus.m_we;
`else
  assign hit1 = hit1_win;
`endif

  // Response mux from the slave that owns the outstanding transaction.
  always_comb begin
    sel_ack  = 1'b0;
    sel_data = '0;
    case (sel_q)
      SelS0: begin
        sel_ack  = bus.s0_ack;
        sel_data = bus.s0_data_r;
      end
      SelS1: begin
        sel_ack  = bus.s1_ack;
        sel_data = bus.s1_data_r;
      end
      default: ;
    endcase
  end

  // Next-state logic and combinational bus outputs.
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    stb0    = 1'b0;
    stb1    = 1'b0;
    stall   = 1'b0;
    ack     = 1'b0;
    data_r  = '0;
    case (state_q)
      StIdle: begin
        stb0  = req & hit0;
        stb1  = req & hit1;
        stall = (hit0 & bus.s0_stall) | (hit1 & bus.s1_stall);
        if (req) begin
          if (hit0) begin
            if (!bus.s0_stall) begin
              sel_d   = SelS0;
              cnt_d   = '0;
              state_d = StWait;
            end
          end else if (hit1) begin
            if (!bus.s1_stall) begin
              sel_d   = SelS1;
              cnt_d   = '0;
              state_d = StWait;
            end
          end else begin
            err_d   = 1'b1;
            state_d = StErr;
          end
        end
      end
      StWait: begin
        stall = 1'b1;
        if (!bus.m_cyc) begin
          // Master abandoned the cycle: drop any late response silently.
          sel_d   = SelNone;
          state_d = StIdle;
        end else if (sel_ack) begin
          // Ack wins over a timeout landing in the same cycle.
          ack     = 1'b1;
          data_r  = sel_data;
          sel_d   = SelNone;
          state_d = StIdle;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          sel_d   = SelNone;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StErr: begin
        stall   = 1'b1;
        state_d = StIdle;
      end
      default: begin
        sel_d   = SelNone;
        state_d = StIdle;
      end
    endcase
  end

  // State, select, timeout counter and registered error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      sel_q   <= SelNone;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign bus.s0_stb   = stb0;
  assign bus.s1_stb   = stb1;
  assign bus.m_stall  = stall;
  assign bus.m_ack    = ack;
  assign bus.m_err    = err_q;
  assign bus.m_data_r = data_r;

endmodule

// File: tb/tb_leiwand_rv32_wb_interconnect.sv
// Self-checking bench for leiwand_rv32_wb_interconnect: directed scenarios followed by random
// transactions, each checked cycle by cycle against an address-map / timing reference model.
module tb_leiwand_rv32_wb_interconnect;

  localparam int unsigned TIMEOUT   = 16;
  localparam longint      SRAM_LO   = 64'h1000_0000;
  localparam longint      SRAM_SIZE = 4 * 128;
  localparam longint      ROM_LO    = 64'h2000_0000;
  localparam longint      ROM_SIZE  = 4 * 128;
`ifdef LEIWAND_RV32_WB_ROM_WP_EN
  localparam bit          ROM_WP    = 1'b1;
`else
  localparam bit          ROM_WP    = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  leiwand_rv32_wb_interconnect_if #(.MEM_WIDTH(32)) bus ();

  leiwand_rv32_wb_interconnect #(
    .MEM_WIDTH      (32),
    .SRAM_BASE      (32'h1000_0000),
    .SRAM_WORDS     (128),
    .ROM_BASE       (32'h2000_0000),
    .ROM_WORDS      (128),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Which slave owns an address: 0 = none (bus error), 1 = SRAM, 2 = ROM.
  function automatic int target(input logic [31:0] addr, input logic we);
    longint a;
    a = longint'(addr);
    if (a >= SRAM_LO && a < SRAM_LO + SRAM_SIZE) return 1;
    if (a >= ROM_LO && a < ROM_LO + ROM_SIZE) begin
      if (ROM_WP && we) return 0;
      return 2;
    end
    return 0;
  endfunction

  function automatic logic [4:0] outs();
    return {bus.s0_stb, bus.s1_stb, bus.m_stall, bus.m_ack, bus.m_err};
  endfunction

  // One master transaction. Cycle 0 is the request cycle. stall_n: cycles the target slave
  // stalls; ack_d: cycles after acceptance the slave acks (0 = never); abort_at: cycle at which
  // the master drops cyc (0 = no abort). One idle cycle follows, checked for quiet outputs.
  task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input int stall_n, input int ack_d, input int abort_at);
    int         tgt, acc, ack_c, err_c, end_c, cyc_end, slv_ack_c;
    logic [4:0] exp_ctl;
    logic       exp_stall;
    tgt       = target(addr, we);
    acc       = (tgt == 0) ? 0 : stall_n;
    ack_c     = -1;
    err_c     = -1;
    slv_ack_c = (ack_d > 0) ? acc + ack_d : -1;
    if (tgt == 0) begin
      err_c = 1;
      end_c = 1;
    end else if (abort_at > 0) begin
      end_c     = abort_at;
      slv_ack_c = abort_at;
    end else if (ack_d > 0 && ack_d < int'(TIMEOUT)) begin
      ack_c = acc + ack_d;
      end_c = ack_c;
    end else begin
      err_c = acc + int'(TIMEOUT);
      end_c = err_c;
    end
    cyc_end = (abort_at > 0) ? abort_at - 1 : end_c;

    for (int c = 0; c <= end_c + 1; c++) begin
      @(negedge clk);
      bus.m_cyc    = (c <= cyc_end);
      bus.m_stb    = (c <= acc);
      bus.m_we     = we;
      bus.m_addr   = addr;
      bus.m_data_w = wdata;
      if (tgt == 1) begin
        bus.s0_stall  = (c < stall_n);
        bus.s0_ack    = (c == slv_ack_c);
        bus.s0_data_r = (c == slv_ack_c) ? rdata : $urandom;
      end else begin
        bus.s0_stall  = (c > end_c) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.s0_ack    = 1'($urandom_range(0, 1));
        bus.s0_data_r = $urandom;
      end
      if (tgt == 2) begin
        bus.s1_stall  = (c < stall_n);
        bus.s1_ack    = (c == slv_ack_c);
        bus.s1_data_r = (c == slv_ack_c) ? rdata : $urandom;
      end else begin
        bus.s1_stall  = (c > end_c) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.s1_ack    = 1'($urandom_range(0, 1));
        bus.s1_data_r = $urandom;
      end
      #2;
      exp_stall = (c < acc) || (c > acc && c <= end_c);
      exp_ctl   = {(tgt == 1 && c <= acc), (tgt == 2 && c <= acc), exp_stall,
                   (c == ack_c), (c == err_c)};
      check($sformatf("%s c%0d stb0/stb1/stall/ack/err", tag, c), 32'(outs()), 32'(exp_ctl));
      check($sformatf("%s c%0d data_r", tag, c), bus.m_data_r, (c == ack_c) ? rdata : 32'h0);
    end
  endtask

  logic [31:0] edges [8];
  logic [31:0] addr;
  int          ack_d;

  initial begin
    edges = '{32'h1000_0000, 32'h1000_01FC, 32'h1000_0200, 32'h0FFF_FFFC,
              32'h2000_0000, 32'h2000_01FC, 32'h2000_0200, 32'hFFFF_FFFC};
    reset         = 1'b0;
    bus.m_cyc     = 1'b0;
    bus.m_stb     = 1'b0;
    bus.m_we      = 1'b0;
    bus.m_addr    = 32'h1000_0000;
    bus.m_data_w  = '0;
    bus.s0_ack    = 1'b0;
    bus.s0_stall  = 1'b0;
    bus.s0_data_r = 32'h5555_5555;
    bus.s1_ack    = 1'b0;
    bus.s1_stall  = 1'b0;
    bus.s1_data_r = 32'hAAAA_AAAA;
    #1;
    check("reset outputs", 32'(outs()), 32'h0);
    check("reset data_r", bus.m_data_r, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_txn("sram_rd", 32'h1000_0008, 1'b0, 32'h0, 32'hDEAD_BEEF, 0, 1, 0);
    run_txn("rom_wr", 32'h2000_001C, 1'b1, 32'h1234_5678, 32'h0, 2, 1, 0);
    run_txn("rom_rd", 32'h2000_0010, 1'b0, 32'h0, 32'h0BAD_F00D, 1, 2, 0);
    run_txn("unmapped", 32'h3000_0000, 1'b0, 32'h0, 32'h0, 0, 1, 0);
    run_txn("timeout", 32'h1000_0000, 1'b0, 32'h0, 32'h0, 0, 0, 0);
    run_txn("after_timeout", 32'h1000_0004, 1'b0, 32'h0, 32'h0123_4567, 0, 2, 0);
    run_txn("sram_top", 32'h1000_01FC, 1'b0, 32'h0, 32'h7777_0001, 0, 1, 0);
    run_txn("sram_end", 32'h1000_0200, 1'b0, 32'h0, 32'h0, 0, 1, 0);
    run_txn("ack_on_limit", 32'h1000_0020, 1'b0, 32'h0, 32'h600D_600D, 0, TIMEOUT - 1, 0);
    run_txn("ack_too_late", 32'h2000_0020, 1'b0, 32'h0, 32'h0, 1, TIMEOUT, 0);
    run_txn("abort", 32'h1000_0010, 1'b0, 32'h0, 32'h0, 1, 0, 3);
    run_txn("after_abort", 32'h2000_0004, 1'b0, 32'h0, 32'h4242_4242, 0, 1, 0);

    // Reset mid-WAIT while the slave is acking: outputs must clear without a clock edge.
    @(negedge clk);
    bus.m_cyc    = 1'b1;
    bus.m_stb    = 1'b1;
    bus.m_we     = 1'b0;
    bus.m_addr   = 32'h1000_0040;
    bus.s0_stall = 1'b0;
    bus.s0_ack   = 1'b0;
    bus.s1_stall = 1'b0;
    bus.s1_ack   = 1'b0;
    @(negedge clk);
    bus.m_stb     = 1'b0;
    bus.s0_ack    = 1'b1;
    bus.s0_data_r = 32'hCAFE_F00D;
    #1;
    check("wait ack before reset", 32'(outs()), 32'b00110);
    check("wait data before reset", bus.m_data_r, 32'hCAFE_F00D);
    #1;
    reset     = 1'b0;
    bus.m_cyc = 1'b0;
    #1;
    check("async reset outputs", 32'(outs()), 32'h0);
    check("async reset data_r", bus.m_data_r, 32'h0);
    @(negedge clk);
    bus.s0_ack = 1'b0;
    reset      = 1'b1;
    run_txn("after_reset", 32'h1000_0044, 1'b0, 32'h0, 32'h1357_9BDF, 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0:       addr = 32'h1000_0000 + ($urandom_range(0, 127) << 2);
        1:       addr = 32'h2000_0000 + ($urandom_range(0, 127) << 2);
        2:       addr = edges[$urandom_range(0, 7)];
        default: addr = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       ack_d = 0;
        1:       ack_d = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
        default: ack_d = $urandom_range(1, 4);
      endcase
      run_txn($sformatf("rnd%0d", i), addr, 1'($urandom_range(0, 1)), $urandom, $urandom,
              $urandom_range(0, 3), ack_d, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
